// File: rtl/dds_pkg.sv
// dds_pkg: definitions shared by the dds generator and the tone frequency
// estimator.
//   LUT_ADDR_W  : phase accumulator width common to generator and estimator
//   fsm_state_t : estimator lock states (SEARCH, MEASURE)
//   clog2       : ceiling log2, for sizing counters from parameters
package dds_pkg;

    localparam int LUT_ADDR_W = 8;

    typedef enum logic [0:0] {
        SEARCH  = 1'b0,
        MEASURE = 1'b1
    } fsm_state_t;

    // Number of bits needed to hold 'value' distinct codes (0 .. value-1).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tone_freq_estimator_seq_divider.sv
// seq_divider: restoring unsigned divider that produces one quotient bit per
// clock, MSB first.
//   clk, rst : clock and synchronous active-high reset (also aborts a division)
//   start    : load num/den and begin; ignored while busy
//   num, den : dividend and divisor, captured when start is accepted
//   busy     : high for the NUM_W iteration cycles after the load edge
//   done     : one-cycle pulse after the last iteration; quo is valid then
//   quo      : quotient, holds until the next accepted start
module seq_divider
    import dds_pkg::*;
#(
    parameter int NUM_W = 11,
    parameter int DEN_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quo
);

    localparam int                ITER_W    = clog2(NUM_W + 1);
    localparam logic [ITER_W-1:0] ITER_LOAD = ITER_W'(NUM_W);
    localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);

    logic [DEN_W-1:0]  rem_r;
    logic [DEN_W-1:0]  den_r;
    logic [ITER_W-1:0] iter_r;
    logic [DEN_W:0]    shift_s;
    logic [DEN_W-1:0]  diff_s;
    logic              fits_s;
    logic [DEN_W-1:0]  rem_next_s;

    // quo doubles as the dividend shift register: its MSB feeds the remainder
    // while quotient bits enter at the LSB.
    assign shift_s    = {rem_r, quo[NUM_W-1]};
    assign fits_s     = (shift_s >= {1'b0, den_r});
    // When the divisor fits, the difference is below den_r, so the low bits
    // of the modular subtraction are the exact result.
    assign diff_s     = shift_s[DEN_W-1:0] - den_r;
    assign rem_next_s = fits_s ? diff_s : shift_s[DEN_W-1:0];

    // Load on start, then one restoring iteration per clock until done.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            quo    <= '0;
            rem_r  <= '0;
            den_r  <= '0;
            iter_r <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy   <= 1'b1;
                quo    <= num;
                den_r  <= den;
                rem_r  <= '0;
                iter_r <= ITER_LOAD;
            end else if (busy) begin
                rem_r  <= rem_next_s;
                quo    <= {quo[NUM_W-2:0], fits_s};
                iter_r <= iter_r - ITER_ONE;
                if (iter_r == ITER_ONE) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tone_freq_estimator.sv
// tone_freq_estimator: measures the period of a signed sinusoid with a
// hysteretic zero-crossing detector, sums 2^AVG_LOG2 periods and converts the
// sum back into the equivalent 8-bit DDS phase increment
// floor(2^(8+AVG_LOG2) / sum), saturated to 255.
//   clk, rst  : clock and synchronous active-high reset
//   x_in      : signed input sample, DATA_W bits
//   x_valid   : sample enable; only valid samples are evaluated and counted
//   est_inc   : estimated phase increment, holds between updates
//   est_valid : one-cycle pulse when est_inc updates
//   locked    : high from the first est_valid until a timeout or rst
//   overrun   : one-cycle pulse when a window is dropped (divider busy)
module tone_freq_estimator
    import dds_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int HYST       = 8,
    parameter int AVG_LOG2   = 2,
    parameter int MAX_PERIOD = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     x_in,
    input  logic                  x_valid,
    output logic [LUT_ADDR_W-1:0] est_inc,
    output logic                  est_valid,
    output logic                  locked,
    output logic                  overrun
);

    localparam int PER_W = clog2(MAX_PERIOD + 1);
    localparam int NUM_W = LUT_ADDR_W + 1 + AVG_LOG2;
    localparam int SUM_W = PER_W + AVG_LOG2;
    localparam int K_W   = AVG_LOG2 + 1;

    localparam logic [NUM_W-1:0]         NUM      = NUM_W'(1) << (LUT_ADDR_W + AVG_LOG2);
    localparam logic [NUM_W-1:0]         SAT_MAX  = NUM_W'((1 << LUT_ADDR_W) - 1);
    localparam logic [K_W-1:0]           K_LAST   = K_W'((1 << AVG_LOG2) - 1);
    localparam logic [PER_W-1:0]         PER_MAX  = PER_W'(MAX_PERIOD);
    localparam logic signed [DATA_W-1:0] HYST_POS = DATA_W'(HYST);
    localparam logic signed [DATA_W-1:0] HYST_NEG = DATA_W'(-HYST);

    fsm_state_t             state_r;
    logic                   schmitt_r;
    logic [PER_W-1:0]       cnt_r;
    logic [SUM_W-1:0]       sum_r;
    logic [K_W-1:0]         k_r;
    logic                   start_r;
    logic [SUM_W-1:0]       den_r;

    logic                   below_s;
    logic                   above_s;
    logic                   event_s;
    logic [PER_W-1:0]       period_s;
    logic [SUM_W-1:0]       sum_next_s;
    logic                   win_done_s;
    logic                   timeout_s;
    logic                   div_engaged_s;
    logic                   accept_s;
    logic                   overrun_s;
    logic                   div_rst_s;
    logic                   div_busy_s;
    logic                   div_done_s;
    logic [NUM_W-1:0]       div_quo_s;
    logic [LUT_ADDR_W-1:0]  est_sat_s;

    assign below_s    = x_valid && ($signed(x_in) <= HYST_NEG);
    assign above_s    = x_valid && ($signed(x_in) >= HYST_POS);
    assign event_s    = above_s && !schmitt_r;
    assign period_s   = cnt_r + PER_W'(1);
    assign sum_next_s = sum_r + SUM_W'(period_s);
    assign win_done_s = (state_r == MEASURE) && event_s && (k_r == K_LAST);
    // An event on the same sample always wins over the timeout.
    assign timeout_s  = (state_r == MEASURE) && x_valid && !event_s && (period_s == PER_MAX);

    // A pending start counts as busy; a done pulse does not, so a window that
    // closes while the previous result is being delivered is still accepted.
    assign div_engaged_s = start_r || div_busy_s;
    assign accept_s      = win_done_s && !div_engaged_s;
    assign overrun_s     = win_done_s && div_engaged_s;

    // Losing lock discards any division in flight along with its result.
    assign div_rst_s = rst || timeout_s;

    assign est_sat_s = (div_quo_s > SAT_MAX) ? LUT_ADDR_W'(SAT_MAX) : div_quo_s[LUT_ADDR_W-1:0];

    seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (SUM_W)
    ) u_div (
        .clk   (clk),
        .rst   (div_rst_s),
        .start (start_r),
        .num   (NUM),
        .den   (den_r),
        .busy  (div_busy_s),
        .done  (div_done_s),
        .quo   (div_quo_s)
    );

    // Schmitt detector, period counter, window accumulator, lock FSM and
    // output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= SEARCH;
            schmitt_r <= 1'b1;
            cnt_r     <= '0;
            sum_r     <= '0;
            k_r       <= '0;
            start_r   <= 1'b0;
            den_r     <= '0;
            est_inc   <= '0;
            est_valid <= 1'b0;
            locked    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            start_r   <= 1'b0;
            est_valid <= 1'b0;
            overrun   <= overrun_s;

            if (below_s) begin
                schmitt_r <= 1'b0;
            end else if (above_s) begin
                schmitt_r <= 1'b1;
            end

            case (state_r)
                SEARCH: begin
                    cnt_r <= '0;
                    sum_r <= '0;
                    k_r   <= '0;
                    if (event_s) begin
                        state_r <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (event_s) begin
                        cnt_r <= '0;
                        if (k_r == K_LAST) begin
                            // Window closed: hand it to the divider or drop it.
                            sum_r <= '0;
                            k_r   <= '0;
                            if (accept_s) begin
                                start_r <= 1'b1;
                                den_r   <= sum_next_s;
                            end
                        end else begin
                            sum_r <= sum_next_s;
                            k_r   <= k_r + K_W'(1);
                        end
                    end else if (timeout_s) begin
                        state_r <= SEARCH;
                        cnt_r   <= '0;
                        sum_r   <= '0;
                        k_r     <= '0;
                        locked  <= 1'b0;
                    end else if (x_valid) begin
                        cnt_r <= cnt_r + PER_W'(1);
                    end
                end
                default: begin
                    state_r <= SEARCH;
                    cnt_r   <= '0;
                    sum_r   <= '0;
                    k_r     <= '0;
                end
            endcase

            if (div_done_s && !timeout_s) begin
                est_inc   <= est_sat_s;
                est_valid <= 1'b1;
                locked    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tone_freq_estimator.sv
module tb_tone_freq_estimator;

    localparam int NUM_W = 11;
    localparam int MAX_P = 1024;
    localparam int HYST  = 8;
    localparam int LAT   = NUM_W + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] x_in;
    logic       x_valid;
    logic [7:0] est_inc;
    logic       est_valid;
    logic       locked;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tone_freq_estimator dut (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .est_inc   (est_inc),
        .est_valid (est_valid),
        .locked    (locked),
        .overrun   (overrun)
    );

    // Sine table of the dds generator, amplitude 127.
    int lut [256];
    int phase;

    // Reference model: event timestamps, list of periods, divider occupancy
    // as a cycle number and a queue of scheduled estimates.
    int cyc;
    bit m_s, m_search, m_locked;
    int m_samples;
    int m_periods[$];
    int m_busy_end;
    int due_q[$];
    int val_q[$];
    int evt_cyc[$];
    int exp_inc;
    bit exp_valid, exp_overrun;

    function automatic int clamp8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int noise(input int amp);
        return int'($urandom_range(2 * amp, 0)) - amp;
    endfunction

    task automatic model_reset();
        m_s = 1'b1; m_search = 1'b1; m_locked = 1'b0; m_samples = 0;
        m_periods.delete(); due_q.delete(); val_q.delete(); evt_cyc.delete();
        m_busy_end = -1000; exp_inc = 0; exp_valid = 1'b0; exp_overrun = 1'b0;
    endtask

    // Drive one sample, advance the model to the same edge, sample after it.
    task automatic drive(input bit r, input bit v, input int x);
        bit rise;
        int sum, q;
        rst = r; x_valid = v; x_in = 8'(x);
        cyc++;
        exp_valid = 1'b0; exp_overrun = 1'b0;
        if (r) begin
            model_reset();
        end else begin
            rise = v && !m_s && (x >= HYST);
            if (v && x <= -HYST) m_s = 1'b0;
            else if (v && x >= HYST) m_s = 1'b1;
            if (rise) evt_cyc.push_back(cyc);
            if (m_search) begin
                if (rise) begin m_search = 1'b0; m_samples = 0; m_periods.delete(); end
            end else if (rise) begin
                m_periods.push_back(m_samples + 1);
                m_samples = 0;
                if (m_periods.size() == 4) begin
                    sum = 0;
                    foreach (m_periods[i]) sum += m_periods[i];
                    if (cyc > m_busy_end) begin
                        q = 1024 / sum;
                        due_q.push_back(cyc + LAT);
                        val_q.push_back(q > 255 ? 255 : q);
                        m_busy_end = cyc + NUM_W + 1;
                    end else begin
                        exp_overrun = 1'b1;
                    end
                    m_periods.delete();
                end
            end else if (v) begin
                m_samples++;
                if (m_samples == MAX_P) begin
                    m_search = 1'b1; m_locked = 1'b0; m_periods.delete();
                    due_q.delete(); val_q.delete(); m_busy_end = cyc;
                end
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                exp_inc = val_q.pop_front();
                exp_valid = 1'b1;
                m_locked = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 0);
        drive(1'b1, 1'b0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (est_inc !== 8'd0) begin errors++; $display("FAIL reset_est_inc: got %0d expected 0", est_inc); end
        checks++;
        if (est_valid !== 1'b0) begin errors++; $display("FAIL reset_est_valid: got %b expected 0", est_valid); end
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_dds13();
        int first_valid;
        first_valid = -1;
        do_reset();
        phase = int'($urandom_range(255, 0));
        for (int n = 0; n < 400; n++) begin
            drive(1'b0, 1'b1, clamp8(lut[phase] + noise(3)));
            phase = (phase + 13) % 256;
            checks++;
            if ({est_valid, overrun, locked} !== {exp_valid, exp_overrun, m_locked}) begin
                errors++;
                $display("FAIL dds13_flags cyc=%0d: valid/overrun/locked got %b%b%b expected %b%b%b",
                         cyc, est_valid, overrun, locked, exp_valid, exp_overrun, m_locked);
            end
            if (exp_valid) begin
                checks++;
                if (est_inc !== 8'(exp_inc)) begin errors++; $display("FAIL dds13_est cyc=%0d: got %0d expected %0d", cyc, est_inc, exp_inc); end
            end
            if (est_valid) begin
                if (first_valid < 0) first_valid = cyc;
                checks++;
                if (est_inc != 8'd12 && est_inc != 8'd13) begin errors++; $display("FAIL dds13_range: got %0d expected 12 or 13", est_inc); end
            end
        end
        checks++;
        if (first_valid < 0 || evt_cyc.size() == 0 || (first_valid - evt_cyc[0]) > 99) begin
            errors++;
            $display("FAIL dds13_first_latency: first est_valid at %0d, first event at %0d, required within 99 samples",
                     first_valid, (evt_cyc.size() > 0) ? evt_cyc[0] : -1);
        end
    endtask

    task automatic test_switch();
        int nvalid;
        do_reset();
        phase = int'($urandom_range(255, 0));
        nvalid = 0;
        for (int n = 0; n < 300; n++) begin
            drive(1'b0, 1'b1, clamp8(lut[phase] + noise(3)));
            phase = (phase + 26) % 256;
            checks++;
            if ({est_valid, overrun, locked} !== {exp_valid, exp_overrun, m_locked}) begin
                errors++;
                $display("FAIL inc26_flags cyc=%0d: valid/overrun/locked got %b%b%b expected %b%b%b",
                         cyc, est_valid, overrun, locked, exp_valid, exp_overrun, m_locked);
            end
            if (est_valid) begin
                nvalid++;
                checks++;
                if (est_inc != 8'd25 && est_inc != 8'd26) begin errors++; $display("FAIL inc26_range: got %0d expected 25 or 26", est_inc); end
            end
        end
        checks++;
        if (nvalid < 3) begin errors++; $display("FAIL inc26_count: got %0d estimates expected at least 3", nvalid); end
        nvalid = 0;
        for (int n = 0; n < 400; n++) begin
            drive(1'b0, 1'b1, clamp8(lut[phase] + noise(3)));
            phase = (phase + 13) % 256;
            checks++;
            if (locked !== 1'b1) begin errors++; $display("FAIL switch_locked cyc=%0d: got %b expected 1", cyc, locked); end
            if (exp_valid) begin
                checks++;
                if (est_inc !== 8'(exp_inc)) begin errors++; $display("FAIL switch_est cyc=%0d: got %0d expected %0d", cyc, est_inc, exp_inc); end
            end
            if (est_valid) begin
                nvalid++;
                if (nvalid >= 3) begin
                    checks++;
                    if (est_inc != 8'd12 && est_inc != 8'd13) begin errors++; $display("FAIL switch_settle: got %0d expected 12 or 13", est_inc); end
                end
            end
        end
        checks++;
        if (nvalid < 3) begin errors++; $display("FAIL switch_count: got %0d estimates expected at least 3", nvalid); end
    endtask

    // Random sample enable; junk on x_in while invalid must be ignored.
    task automatic test_gated();
        bit v;
        int nvalid;
        do_reset();
        phase = int'($urandom_range(255, 0));
        nvalid = 0;
        for (int n = 0; n < 700; n++) begin
            v = ($urandom_range(9, 0) < 7);
            if (v) begin
                drive(1'b0, 1'b1, clamp8(lut[phase] + noise(3)));
                phase = (phase + 13) % 256;
            end else begin
                drive(1'b0, 1'b0, int'($urandom_range(255, 0)) - 128);
            end
            checks++;
            if ({est_valid, overrun, locked} !== {exp_valid, exp_overrun, m_locked}) begin
                errors++;
                $display("FAIL gated_flags cyc=%0d: valid/overrun/locked got %b%b%b expected %b%b%b",
                         cyc, est_valid, overrun, locked, exp_valid, exp_overrun, m_locked);
            end
            if (est_valid) begin
                nvalid++;
                checks++;
                if (est_inc != 8'd12 && est_inc != 8'd13) begin errors++; $display("FAIL gated_range: got %0d expected 12 or 13", est_inc); end
            end
        end
        checks++;
        if (nvalid < 2) begin errors++; $display("FAIL gated_count: got %0d estimates expected at least 2", nvalid); end
    endtask

    task automatic test_square();
        int nvalid;
        do_reset();
        nvalid = 0;
        for (int n = 0; n < 400; n++) begin
            drive(1'b0, 1'b1, (((n % 20) < 10) ? 100 : -100) + noise(5));
            checks++;
            if ({est_valid, overrun, locked} !== {exp_valid, exp_overrun, m_locked}) begin
                errors++;
                $display("FAIL square_flags cyc=%0d: valid/overrun/locked got %b%b%b expected %b%b%b",
                         cyc, est_valid, overrun, locked, exp_valid, exp_overrun, m_locked);
            end
            if (est_valid) begin
                nvalid++;
                checks++;
                if (est_inc !== 8'd12) begin errors++; $display("FAIL square_est: got %0d expected 12", est_inc); end
            end
        end
        checks++;
        if (nvalid < 3) begin errors++; $display("FAIL square_count: got %0d estimates expected at least 3", nvalid); end
    endtask

    task automatic test_inc128();
        int nvalid, nover;
        do_reset();
        phase = 48 + int'($urandom_range(32, 0));
        nvalid = 0; nover = 0;
        for (int n = 0; n < 240; n++) begin
            drive(1'b0, 1'b1, lut[phase]);
            phase = (phase + 128) % 256;
            checks++;
            if ({est_valid, overrun, locked} !== {exp_valid, exp_overrun, m_locked}) begin
                errors++;
                $display("FAIL inc128_flags cyc=%0d: valid/overrun/locked got %b%b%b expected %b%b%b",
                         cyc, est_valid, overrun, locked, exp_valid, exp_overrun, m_locked);
            end
            if (overrun) nover++;
            if (est_valid) begin
                nvalid++;
                checks++;
                if (est_inc !== 8'd128) begin errors++; $display("FAIL inc128_est: got %0d expected 128", est_inc); end
            end
        end
        checks++;
        if (nvalid < 5 || nover < 5 || (nvalid - nover) > 1 || (nover - nvalid) > 1) begin
            errors++;
            $display("FAIL inc128_alternate: got %0d estimates and %0d overruns expected equal within 1", nvalid, nover);
        end
    endtask

    task automatic test_timeout();
        int last_evt, fall, post_valid, first_valid;
        do_reset();
        phase = int'($urandom_range(255, 0));
        for (int n = 0; n < 200; n++) begin
            drive(1'b0, 1'b1, clamp8(lut[phase] + noise(3)));
            phase = (phase + 13) % 256;
        end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL timeout_prelock: got %b expected 1", locked); end
        last_evt = (evt_cyc.size() > 0) ? evt_cyc[evt_cyc.size() - 1] : -1;
        fall = -1; post_valid = 0;
        for (int n = 0; n < 1100; n++) begin
            drive(1'b0, 1'b1, 0);
            checks++;
            if ({est_valid, overrun, locked} !== {exp_valid, exp_overrun, m_locked}) begin
                errors++;
                $display("FAIL timeout_flags cyc=%0d: valid/overrun/locked got %b%b%b expected %b%b%b",
                         cyc, est_valid, overrun, locked, exp_valid, exp_overrun, m_locked);
            end
            if (fall < 0 && !locked) fall = cyc;
            if (fall >= 0 && est_valid) post_valid++;
        end
        checks++;
        if (fall - last_evt != MAX_P) begin errors++; $display("FAIL timeout_fall: locked fell %0d samples after last event expected %0d", fall - last_evt, MAX_P); end
        checks++;
        if (post_valid != 0) begin errors++; $display("FAIL timeout_no_est: got %0d est_valid after timeout expected 0", post_valid); end
        evt_cyc.delete();
        first_valid = -1;
        for (int n = 0; n < 250; n++) begin
            drive(1'b0, 1'b1, clamp8(lut[phase] + noise(3)));
            phase = (phase + 13) % 256;
            if (est_valid && first_valid < 0) first_valid = cyc;
        end
        checks++;
        if (evt_cyc.size() < 5 || first_valid != evt_cyc[4] + LAT) begin
            errors++;
            $display("FAIL relock_latency: first est_valid at %0d expected %0d",
                     first_valid, (evt_cyc.size() >= 5) ? evt_cyc[4] + LAT : -1);
        end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL relock_locked: got %b expected 1", locked); end
    endtask

    task automatic test_reset_mid_division();
        bit pending;
        do_reset();
        phase = int'($urandom_range(255, 0));
        pending = 1'b0;
        for (int n = 0; n < 400 && !pending; n++) begin
            drive(1'b0, 1'b1, clamp8(lut[phase] + noise(3)));
            phase = (phase + 13) % 256;
            pending = (due_q.size() > 0);
        end
        checks++;
        if (!pending) begin errors++; $display("FAIL rstdiv_no_window: got no window in 400 samples expected one"); end
        for (int n = 0; n < 3; n++) begin
            drive(1'b0, 1'b1, clamp8(lut[phase] + noise(3)));
            phase = (phase + 13) % 256;
        end
        drive(1'b1, 1'b0, 0);
        checks++;
        if ({est_inc, est_valid, locked, overrun} !== 11'd0) begin
            errors++;
            $display("FAIL rstdiv_outputs: est_inc/valid/locked/overrun got %0d/%b/%b/%b expected 0/0/0/0", est_inc, est_valid, locked, overrun);
        end
        for (int n = 0; n < 30; n++) begin
            drive(1'b0, 1'b0, int'($urandom_range(255, 0)) - 128);
            checks++;
            if ({est_valid, locked} !== 2'b00) begin errors++; $display("FAIL rstdiv_aborted cyc=%0d: valid/locked got %b%b expected 00", cyc, est_valid, locked); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) lut[i] = int'(127.0 * $sin(2.0 * 3.14159265358979 * i / 256.0));
        rst = 1'b1; x_valid = 1'b0; x_in = 8'd0; cyc = 0;
        model_reset();
        test_reset();
        test_dds13();
        test_switch();
        test_gated();
        test_square();
        test_inc128();
        test_timeout();
        test_reset_mid_division();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tone_freq_estimator.md
# tone_freq_estimator

Receive-side counterpart of the `dds` generator. It takes a signed 8-bit sinusoid, such as a `dds` output or the FIR-filtered mixer product, and measures its period with hysteretic zero-crossing detection. It averages the period over 2^AVG_LOG2 cycles and converts the result back into the equivalent 8-bit DDS phase increment, so a bench or controller can close the loop on `phase_increment`.

## Interface
- DATA_W, 8, sample width (signed)
- HYST, 8, hysteresis threshold magnitude, in LSBs
- AVG_LOG2, 2, number of periods averaged per estimate = 2^AVG_LOG2
- MAX_PERIOD, 1024, samples without a rising event before lock is lost
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- x_in  in  DATA_W  signed input sample
- x_valid  in  1  x_in is valid this cycle (sample enable)
- est_inc  out  8  estimated phase increment = floor(2^(8+AVG_LOG2) / period_sum), saturated to 255; holds its value between updates
- est_valid  out  1  one-cycle pulse when est_inc updates
- locked  out  1  high from the first est_valid until a timeout or rst
- overrun  out  1  one-cycle pulse when a completed window is dropped because the divider is busy

## Operation
- Schmitt state s, reset value 1:
  - s←0 when x_valid && x_in <= −HYST.
  - s←1 when x_valid && x_in >= +HYST.
  - Rising event = s transitions 0→1.
  - Only x_valid cycles are evaluated.
- Period counter cnt (PER_W = clog2(MAX_PERIOD+1) bits):
  - On an x_valid cycle without an event: cnt←cnt+1.
  - On an event: period = cnt+1, then cnt←0.
- FSM states:
  - SEARCH: wait for the first rising event. On the event: cnt←0, sum←0, k←0, go to MEASURE.
  - MEASURE: on each event, sum←sum+period and k←k+1. When k reaches 2^AVG_LOG2:
    - Window completes; the full sum is latched into the divider and the divider starts.
    - sum and k clear; measurement continues in MEASURE, so windows are back-to-back.
    - If the divider is still busy, the window is discarded instead, overrun pulses, and sum/k still clear.
- Timeout: in MEASURE, if cnt+1 reaches MAX_PERIOD with no event:
  - Go to SEARCH; clear locked, sum, k.
  - An in-flight division is aborted: no est_valid is generated.
- Division: numerator 2^(8+AVG_LOG2) (NUM_W = 9+AVG_LOG2 bits); divisor = sum (PER_W+AVG_LOG2 bits).
  - Quotient truncated, then saturated: a quotient > 255 gives est_inc = 255.
  - A divisor of 0 cannot occur, because each period is ≥ 2 samples under hysteresis.
- locked is set on the same edge as est_valid.
- Simultaneous events:
  - A timeout and an event in the same cycle: the event wins, and the timeout is not taken.
  - Window completion and divider done in the same cycle: the new window is accepted, with no overrun.

## Timing
- Reset values: est_inc=0, est_valid=0, locked=0, overrun=0, FSM=SEARCH, s=1, cnt=0, sum=0, k=0, divider idle. rst asserted mid-division aborts the division.
- Event latency: the event registers on the edge that samples the qualifying x_in.
- Estimate latency: est_valid is high in cycle T+NUM_W+2, where T is the edge registering the window-closing event.
  - One cycle to load the divider, NUM_W iterations, one cycle to saturate and register.
- Divider busy window: cycles T+1 … T+NUM_W+1. A window closing in this range gives overrun.
- Timeout is detected on the x_valid edge where cnt+1 = MAX_PERIOD. locked drops on that edge.

## Structure
- Shared package `dds_pkg` holds:
  - LUT_ADDR_W = 8 (phase accumulator width common with `dds`)
  - FSM state enum (SEARCH, MEASURE)
  - clog2 helper function
- One sub-module, `seq_divider`: restoring unsigned divider, one quotient bit per cycle.
  - Ports: start, busy, done, num, den, quo.
  - Parameterised by NUM_W and DEN_W.
  - Synchronous rst.
- Top level contains the Schmitt detector, cnt, window accumulator, FSM, saturation and output registers.

## Test plan
- `dds` phase_increment=13 driving x_in, x_valid=1 every cycle → first est_valid within 5 periods of the first rising event, est_inc ∈ {12,13}, locked=1, no overrun.
- `dds` phase_increment=26, x_valid=1 → est_inc ∈ {25,26}. Then switch the increment to 13 without reset → est_inc settles to {12,13} within 2 windows, locked stays 1.
- ±5 LSB noise riding on a 20-sample-period square wave of ±100 → no spurious events, every est_inc=12 (1024/80).
- Increment 128 (period 2 samples, window 8 cycles, NUM_W=11 divider busy 12 cycles) → overrun pulses on alternate windows, est_inc=128 on every est_valid.
- Lock then hold x_in=0 for MAX_PERIOD samples → locked falls on sample 1024 after the last event, no est_valid afterwards. Restoring the tone relocks after 2^AVG_LOG2+1 rising events plus divider latency.
- Assert rst for 1 cycle during a division → next cycle all outputs at reset values, FSM=SEARCH, no est_valid from the aborted division.
